// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}; dp is always off.
package seg_scan_driver_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Scan position of each field on the panel, right to left.
    localparam logic [2:0] POS_R_ONES  = 3'd0;
    localparam logic [2:0] POS_R_TENS  = 3'd1;
    localparam logic [2:0] POS_BLANK_R = 3'd2;
    localparam logic [2:0] POS_M_ONES  = 3'd3;
    localparam logic [2:0] POS_M_TENS  = 3'd4;
    localparam logic [2:0] POS_BLANK_M = 3'd5;
    localparam logic [2:0] POS_L_ONES  = 3'd6;
    localparam logic [2:0] POS_L_TENS  = 3'd7;

    typedef struct packed {
        logic [5:0] left;
        logic [5:0] middle;
        logic [5:0] right;
    } snap_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    function automatic bcd_t to_bcd(input logic [5:0] v);
        bcd_t r;
        r.tens = 4'(v / 6'd10);
        r.ones = 4'(v % 6'd10);
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_driver_seg_decode.sv
// seg_decode: BCD digit plus blank flag to active-low segment pattern.
// Purely combinational; out-of-range digits render blank.
module seg_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed seven-segment scanner plus blinking LED driver (LEADING_ZERO_BLANK_EN blanks zero tens digits).
// Latency: LEDs 1 cycle, displayed values up to one frame (8*SCAN_DIV); no backpressure, inputs are sampled freely.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       cp,
    input  logic       rst,
    input  logic [5:0] showLeft,
    input  logic [5:0] showMiddle,
    input  logic [5:0] showRight,
    input  logic [9:0] LEDMsg,
    input  logic [2:0] shinning,
    output logic [7:0] digitSel,
    output logic [7:0] segOut,
    output logic [9:0] ledOut
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [2:0]         scan_idx_q,  scan_idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q,  blink_on_d;
    snap_t              snap_q,      snap_d;
    logic [7:0]         digit_sel_q, digit_sel_d;
    logic [7:0]         seg_q,       seg_d;
    logic [9:0]         led_q,       led_d;

    logic       scan_tc;
    logic       blink_tc;
    bcd_t       l_bcd, m_bcd, r_bcd;
    logic [3:0] dec_digit;
    logic       dec_blank;
    logic [7:0] dec_seg;
    logic [9:0] blink_mask;

    // The wrap edge decodes digit 0 from the freshly captured snapshot so
    // that no frame ever mixes old and new values.
    always_comb begin
        scan_tc    = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_tc ? '0 : scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_tc ? scan_idx_q + 3'd1 : scan_idx_q;
        snap_d     = snap_q;
        if (scan_tc && (scan_idx_q == 3'(NUM_DIGITS - 1))) begin
            snap_d = {showLeft, showMiddle, showRight};
        end

        l_bcd = to_bcd(snap_d.left);
        m_bcd = to_bcd(snap_d.middle);
        r_bcd = to_bcd(snap_d.right);

        dec_digit = 4'd0;
        dec_blank = 1'b1;
        case (scan_idx_d)
            POS_R_ONES: begin dec_digit = r_bcd.ones; dec_blank = 1'b0; end
            POS_R_TENS: begin dec_digit = r_bcd.tens; dec_blank = LZ_BLANK && (r_bcd.tens == 4'd0); end
            POS_M_ONES: begin dec_digit = m_bcd.ones; dec_blank = 1'b0; end
            POS_M_TENS: begin dec_digit = m_bcd.tens; dec_blank = LZ_BLANK && (m_bcd.tens == 4'd0); end
            POS_L_ONES: begin dec_digit = l_bcd.ones; dec_blank = 1'b0; end
            POS_L_TENS: begin dec_digit = l_bcd.tens; dec_blank = LZ_BLANK && (l_bcd.tens == 4'd0); end
            POS_BLANK_R, POS_BLANK_M: dec_blank = 1'b1;
            default: dec_blank = 1'b1;
        endcase
    end

    seg_decode u_seg_decode (
        .digit (dec_digit),
        .blank (dec_blank),
        .seg   (dec_seg)
    );

    always_comb begin
        digit_sel_d = scan_tc ? ~(8'd1 << scan_idx_d) : digit_sel_q;
        seg_d       = scan_tc ? dec_seg : seg_q;

        blink_tc    = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        blink_cnt_d = blink_tc ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_on_d  = blink_tc ? ~blink_on_q : blink_on_q;

        // shinning = s selects LED 7-s; LEDs 8 and 9 are never selected.
        blink_mask  = {2'b00, 8'h80 >> shinning};
        led_d       = LEDMsg & ~(blink_on_q ? 10'h000 : blink_mask);
    end

    always_ff @(posedge cp) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            snap_q      <= '0;
            digit_sel_q <= 8'hFF;
            seg_q       <= SEG_BLANK;
            led_q       <= 10'h000;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            snap_q      <= snap_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
            led_q       <= led_d;
        end
    end

    assign digitSel = digit_sel_q;
    assign segOut   = seg_q;
    assign ledOut   = led_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: time-based reference model (cycles since reset) checked every cycle,
// plus directed literal expectations for reset, frame content, frame consistency and blinking.
module tb_seg_scan_driver;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;
    localparam int FRAME     = 8 * SCAN_DIV;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       cp = 1'b0;
    logic       rst;
    logic [5:0] showLeft, showMiddle, showRight;
    logic [9:0] LEDMsg;
    logic [2:0] shinning;
    logic [7:0] digitSel, segOut;
    logic [9:0] ledOut;

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .cp         (cp),
        .rst        (rst),
        .showLeft   (showLeft),
        .showMiddle (showMiddle),
        .showRight  (showRight),
        .LEDMsg     (LEDMsg),
        .shinning   (shinning),
        .digitSel   (digitSel),
        .segOut     (segOut),
        .ledOut     (ledOut)
    );

    always #5 cp = ~cp;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: everything follows from the number of edges since the last reset edge.
    int         m_n     = 0;
    bit         m_valid = 1'b0;
    logic [5:0] m_l = '0, m_m = '0, m_r = '0;
    logic [9:0] m_led = '0;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] tens_of(input int v);
        if (LZB && (v / 10) == 0) return 8'hFF;
        return seg_of(v / 10);
    endfunction

    function automatic logic [7:0] exp_dsel(input int n);
        logic [7:0] one_hot;
        if (n < SCAN_DIV) return 8'hFF;
        one_hot = 8'd1 << ((n / SCAN_DIV) % 8);
        return ~one_hot;
    endfunction

    function automatic logic [7:0] exp_seg(input int n, input int l, input int m, input int r);
        if (n < SCAN_DIV) return 8'hFF;
        case ((n / SCAN_DIV) % 8)
            0: return seg_of(r % 10);
            1: return tens_of(r);
            3: return seg_of(m % 10);
            4: return tens_of(m);
            6: return seg_of(l % 10);
            7: return tens_of(l);
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [9:0] model_led(input logic [9:0] msg, input logic [2:0] s, input int n);
        logic [9:0] res;
        bit         on;
        res = msg;
        on  = ((n / BLINK_DIV) % 2) == 0;
        for (int i = 0; i < 10; i++) begin
            if (!on && i == 7 - int'(s)) res[i] = 1'b0;
        end
        return res;
    endfunction

    always @(posedge cp) begin
        m_valid <= 1'b1;
        if (rst) begin
            m_n   <= 0;
            m_l   <= '0;
            m_m   <= '0;
            m_r   <= '0;
            m_led <= '0;
        end else begin
            m_led <= model_led(LEDMsg, shinning, m_n);
            m_n   <= m_n + 1;
            if ((m_n + 1) % FRAME == 0) begin
                m_l <= showLeft;
                m_m <= showMiddle;
                m_r <= showRight;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (n=%0d, t=%0t)", name, act, exp, m_n, $time);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic step();
        @(negedge cp);
        if (m_valid) begin
            chk("digitSel", 32'(digitSel), 32'(exp_dsel(m_n)));
            chk("segOut",   32'(segOut),   32'(exp_seg(m_n, int'(m_l), int'(m_m), int'(m_r))));
            chk("ledOut",   32'(ledOut),   32'(m_led));
        end
    endtask

    task automatic wait_n(input int target);
        int guard;
        guard = 0;
        while (m_n != target && guard < 2000) begin
            step();
            guard++;
        end
        if (m_n != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_n: cycle count %0d never reached %0d", m_n, target);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        chk("rst_dsel", 32'(digitSel), 32'h0FF);
        chk("rst_seg",  32'(segOut),   32'h0FF);
        chk("rst_led",  32'(ledOut),   32'h000);
        rst = 1'b0;
        repeat (3) begin
            step();
            chk("dark_after_rst", 32'(digitSel), 32'h0FF);
        end
    endtask

    logic [7:0] frame_exp [8];

    initial begin
        rst = 1'b1;
        showLeft = '0; showMiddle = '0; showRight = '0;
        LEDMsg = '0; shinning = '0;

        // Reset held 3 cycles, then first digit k=1 after 4 cycles.
        repeat (3) step();
        chk("rst_dsel", 32'(digitSel), 32'h0FF);
        chk("rst_seg",  32'(segOut),   32'h0FF);
        chk("rst_led",  32'(ledOut),   32'h000);
        rst = 1'b0;
        repeat (3) begin
            step();
            chk("dark_after_rst", 32'(digitSel), 32'h0FF);
        end
        step();
        chk("first_dsel", 32'(digitSel), 32'h0FD);
        chk("first_seg",  32'(segOut),   LZB ? 32'h0FF : 32'h0C0);

        // 63 / 10 / 5 shown in the second frame.
        showLeft = 6'd63; showMiddle = 6'd10; showRight = 6'd5;
        frame_exp = '{8'h92, 8'hC0, 8'hFF, 8'hC0, 8'hF9, 8'hFF, 8'hB0, 8'h82};
        if (LZB) frame_exp[1] = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            wait_n(FRAME + SCAN_DIV * k + 1);
            chk("frame_seg", 32'(segOut), 32'(frame_exp[k]));
        end

        // Change right value mid-frame; only the next frame shows it.
        wait_n(2 * FRAME + 1);
        chk("old_right", 32'(segOut), 32'h092);
        wait_n(2 * FRAME + 3 * SCAN_DIV);
        showRight = 6'd9;
        wait_n(3 * FRAME - 1);
        chk("frame_keeps_old", 32'(m_r), 32'd5);
        wait_n(3 * FRAME + 1);
        chk("new_right", 32'(segOut), 32'h090);
        wait_n(3 * FRAME + SCAN_DIV + 1);
        chk("new_right_tens", 32'(segOut), LZB ? 32'h0FF : 32'h0C0);

        // Blink of LED 7 with all LEDs on.
        LEDMsg = 10'h3FF; shinning = 3'd0;
        reset_pulse();
        wait_n(10);
        chk("blink_on",  32'(ledOut), 32'h3FF);
        wait_n(20);
        chk("blink_off", 32'(ledOut), 32'h37F);
        wait_n(40);
        chk("blink_on2", 32'(ledOut), 32'h3FF);

        // Selected LED is off in the status word: nothing visibly blinks.
        LEDMsg = 10'h100; shinning = 3'd7;
        wait_n(55);
        chk("gated_off_phase", 32'(ledOut), 32'h100);
        wait_n(70);
        chk("gated_on_phase",  32'(ledOut), 32'h100);

        // Reset at scan position 5.
        wait_n(5 * SCAN_DIV + 1 + 2 * FRAME);
        chk("k5_dsel", 32'(digitSel), 32'h0DF);
        reset_pulse();
        step();
        chk("restart_dsel", 32'(digitSel), 32'h0FD);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 7) == 0) LEDMsg = 10'($urandom);
            if ($urandom_range(0, 5) == 0) shinning = 3'($urandom);
            if ($urandom_range(0, 19) == 0) showLeft = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) showMiddle = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) showRight = 6'($urandom_range(0, 63));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
